// File: rtl/spi_sram_responder_pkg.sv
// Shared definitions for the SPI SRAM responder: instruction codes,
// addressing modes, FSM states and the instruction decoder.
package spi_sram_responder_pkg;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_RDMR  = 8'h05;
  localparam logic [7:0] CMD_WRMR  = 8'h01;

  typedef enum logic [1:0] {
    MODE_BYTE    = 2'b00,
    MODE_SEQ     = 2'b01,
    MODE_PAGE    = 2'b10,
    MODE_SEQ_ALT = 2'b11
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WR_DATA,
    ST_RD_DATA,
    ST_RDMR,
    ST_WRMR,
    ST_IGNORE
  } state_t;

  function automatic state_t cmd_decode(input logic [7:0] cmd);
    case (cmd)
      CMD_READ, CMD_WRITE: return ST_ADDR;
      CMD_RDMR:            return ST_RDMR;
      CMD_WRMR:            return ST_WRMR;
      default:             return ST_IGNORE;
    endcase
  endfunction

endpackage

// File: rtl/spi_sram_responder_if.sv
// SPI pad-side bundle: the initiator (master) drives clock, select, data
// and hold; the responder (slave) drives serial out and its enable.
interface spi_sram_responder_if;
  logic mem_sck;
  logic mem_cs_n;
  logic mem_si;
  logic mem_hold_n;
  logic mem_so;
  logic mem_so_oe;

  modport master (output mem_sck, mem_cs_n, mem_si, mem_hold_n,
                  input  mem_so, mem_so_oe);
  modport slave  (input  mem_sck, mem_cs_n, mem_si, mem_hold_n,
                  output mem_so, mem_so_oe);
endinterface

// File: rtl/spi_sram_responder_sync.sv
// Multi-stage synchronizers for the asynchronous SPI inputs plus
// single-clk rise/fall pulses of the synchronized SCK.
module spi_sram_responder_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic i_sck,
  input  logic i_cs_n,
  input  logic i_si,
  input  logic i_hold_n,
  output logic o_sck_rise,
  output logic o_sck_fall,
  output logic o_cs_act,
  output logic o_si,
  output logic o_hold_n
);

  logic [SYNC_STAGES-1:0] r_sck_s, r_cs_s, r_si_s, r_hold_s;
  logic                   r_sck_d;

  // Left unreset so a reset cannot fake a cs-inactive observation.
  always_ff @(posedge clk) begin
    r_sck_s  <= {r_sck_s[SYNC_STAGES-2:0], i_sck};
    r_cs_s   <= {r_cs_s[SYNC_STAGES-2:0], i_cs_n};
    r_si_s   <= {r_si_s[SYNC_STAGES-2:0], i_si};
    r_hold_s <= {r_hold_s[SYNC_STAGES-2:0], i_hold_n};
    r_sck_d  <= r_sck_s[SYNC_STAGES-1];
  end

  assign o_sck_rise = r_sck_s[SYNC_STAGES-1] & ~r_sck_d;
  assign o_sck_fall = ~r_sck_s[SYNC_STAGES-1] & r_sck_d;
  assign o_cs_act   = ~r_cs_s[SYNC_STAGES-1];
  assign o_si       = r_si_s[SYNC_STAGES-1];
  assign o_hold_n   = r_hold_s[SYNC_STAGES-1];

endmodule

// File: rtl/spi_sram_responder.sv
// SPI mode-0 serial SRAM responder with a 2^MEM_ADDR_WIDTH byte array.
// Optional HOLD support: define SPI_SRAM_RESPONDER_HOLD_EN.
module spi_sram_responder
  import spi_sram_responder_pkg::*;
#(
  parameter int unsigned MEM_ADDR_WIDTH = 12,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic                       clk,
  input  logic                       sync_reset,
  spi_sram_responder_if.slave        mem,
  output logic                       busy,
  output logic                       cmd_error
);

  localparam int unsigned AW = MEM_ADDR_WIDTH;

  logic w_sck_rise, w_sck_fall, w_cs_act, w_si, w_hold_n;

  spi_sram_responder_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .i_sck      (mem.mem_sck),
    .i_cs_n     (mem.mem_cs_n),
    .i_si       (mem.mem_si),
    .i_hold_n   (mem.mem_hold_n),
    .o_sck_rise (w_sck_rise),
    .o_sck_fall (w_sck_fall),
    .o_cs_act   (w_cs_act),
    .o_si       (w_si),
    .o_hold_n   (w_hold_n)
  );

  logic w_hold;
`ifdef SPI_SRAM_RESPONDER_HOLD_EN
  assign w_hold = w_cs_act & ~w_hold_n;
`else
  logic w_unused_hold;
  assign w_unused_hold = w_hold_n;
  assign w_hold        = 1'b0;
`endif

  state_t        r_state, w_next;
  mode_t         r_mode;
  logic          r_armed, r_busy, r_is_read, r_so;
  logic [4:0]    r_bit_cnt;
  logic [6:0]    r_shift;
  logic [7:0]    r_tx, r_rdata;
  logic [1:0]    r_load;
  logic [AW-1:0] r_addr, w_addr_next;
  logic [7:0]    r_mem [0:(2**AW)-1];

  logic       w_sel, w_rise, w_fall, w_last, w_done, w_rd_state;
  logic [7:0] w_rx;

  // r_armed requires cs to be seen inactive after reset before a new frame.
  assign w_sel      = w_cs_act & r_armed;
  assign w_rise     = w_sck_rise & w_sel & ~w_hold;
  assign w_fall     = w_sck_fall & w_sel & ~w_hold;
  assign w_rx       = {r_shift, w_si};
  assign w_last     = (r_state == ST_ADDR) ? (r_bit_cnt == 5'd23) : (r_bit_cnt == 5'd7);
  assign w_done     = w_rise & w_last;
  assign w_rd_state = (r_state == ST_RD_DATA) || (r_state == ST_RDMR);

  always_comb begin
    w_addr_next = r_addr + 1'b1;
    if (r_mode == MODE_PAGE) w_addr_next = {r_addr[AW-1:5], r_addr[4:0] + 5'd1};
  end

  always_ff @(posedge clk) begin
    if (sync_reset) r_state <= ST_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (!w_sel) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:    w_next = ST_CMD;
        ST_CMD:     if (w_done) w_next = cmd_decode(w_rx);
        ST_ADDR:    if (w_done) w_next = r_is_read ? ST_RD_DATA : ST_WR_DATA;
        ST_WR_DATA,
        ST_RD_DATA: if (w_done && r_mode == MODE_BYTE) w_next = ST_IGNORE;
        ST_WRMR:    if (w_done) w_next = ST_IGNORE;
        default:    w_next = r_state;
      endcase
    end
  end

  always_comb begin
    mem.mem_so_oe = w_sel & ~w_hold & w_rd_state;
    mem.mem_so    = w_rd_state ? r_so : 1'b0;
    cmd_error     = (r_state == ST_CMD) && w_done && (cmd_decode(w_rx) == ST_IGNORE);
    busy          = r_busy;
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      r_armed   <= 1'b0;
      r_busy    <= 1'b0;
      r_mode    <= MODE_SEQ;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_so      <= 1'b0;
      r_tx      <= '0;
      r_load    <= '0;
      r_is_read <= 1'b0;
      r_addr    <= '0;
    end else begin
      r_busy <= w_cs_act;
      if (!w_cs_act) r_armed <= 1'b1;

      if (w_fall && w_rd_state) begin
        r_so <= r_tx[7];
        r_tx <= {r_tx[6:0], 1'b0};
      end else if (!w_rd_state) begin
        r_so <= 1'b0;
      end

      // Read data is fetched two clks after the address settles:
      // one for the array read register, one to transfer into r_tx.
      r_load <= {r_load[0], 1'b0};
      if (r_load[1]) r_tx <= r_rdata;

      if (!w_sel) begin
        r_bit_cnt <= '0;
        r_shift   <= '0;
      end else if (w_rise) begin
        r_shift   <= w_rx[6:0];
        r_bit_cnt <= w_last ? 5'd0 : r_bit_cnt + 5'd1;
        if (r_state == ST_ADDR) r_addr <= {r_addr[AW-2:0], w_si};
      end

      if (w_done) begin
        case (r_state)
          ST_CMD: begin
            r_is_read <= (w_rx == CMD_READ);
            if (w_rx == CMD_RDMR) r_tx <= {r_mode, 6'b0};
          end
          ST_ADDR:    if (r_is_read) r_load[0] <= 1'b1;
          ST_RD_DATA: begin
            r_addr    <= w_addr_next;
            r_load[0] <= 1'b1;
          end
          ST_WR_DATA: r_addr <= w_addr_next;
          ST_WRMR:    r_mode <= mode_t'(w_rx[7:6]);
          ST_RDMR:    r_tx   <= {r_mode, 6'b0};
          default:    ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!sync_reset && r_state == ST_WR_DATA && w_done) r_mem[r_addr] <= w_rx;
    r_rdata <= r_mem[r_addr];
  end

endmodule

// File: tb/tb_spi_sram_responder.sv
// Directed bench for spi_sram_responder; HOLD steps compile in when
// SPI_SRAM_RESPONDER_HOLD_EN is defined.
module tb_spi_sram_responder;

  localparam int HALF = 8;

  logic clk = 1'b0;
  logic sync_reset;
  logic busy, cmd_error;

  spi_sram_responder_if bus();

  spi_sram_responder #(.MEM_ADDR_WIDTH(12), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .sync_reset (sync_reset),
    .mem        (bus),
    .busy       (busy),
    .cmd_error  (cmd_error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int oe_cnt = 0;
  int err_pulses = 0;

  always @(negedge clk) begin
    if (bus.mem_so_oe === 1'b1) oe_cnt++;
    if (cmd_error === 1'b1) err_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < n; i++) begin
      bus.mem_si = tx[7-i];
      wait_clk(HALF);
      rx = {rx[6:0], bus.mem_so};
      bus.mem_sck = 1'b1;
      wait_clk(HALF);
      bus.mem_sck = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    spi_bits(tx, 8, rx);
  endtask

  task automatic cs_start();
    bus.mem_cs_n = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic cs_stop();
    wait_clk(HALF);
    bus.mem_cs_n = 1'b1;
    wait_clk(2*HALF);
  endtask

  task automatic cmd_addr(input logic [7:0] cmd, input logic [23:0] addr);
    logic [7:0] d;
    spi_byte(cmd, d);
    spi_byte(addr[23:16], d);
    spi_byte(addr[15:8], d);
    spi_byte(addr[7:0], d);
  endtask

  task automatic set_mode(input logic [7:0] m);
    logic [7:0] d;
    cs_start();
    spi_byte(8'h01, d);
    spi_byte(m, d);
    cs_stop();
  endtask

  initial begin
    logic [7:0] rx, rx2, rhi, rlo;
    int p0, o0;

    bus.mem_sck    = 1'b0;
    bus.mem_cs_n   = 1'b1;
    bus.mem_si     = 1'b0;
    bus.mem_hold_n = 1'b1;
    sync_reset     = 1'b1;
    wait_clk(5);
    check("rst_busy", 32'(busy), 0);
    check("rst_oe", 32'(bus.mem_so_oe), 0);
    check("rst_so", 32'(bus.mem_so), 0);
    check("rst_cmd_error", 32'(cmd_error), 0);
    sync_reset = 1'b0;
    wait_clk(4);

    // Sequential write then read back
    cs_start();
    check("busy_active", 32'(busy), 1);
    cmd_addr(8'h02, 24'h000010);
    spi_byte(8'hA5, rx);
    spi_byte(8'h5A, rx);
    cs_stop();
    check("busy_idle", 32'(busy), 0);
    cs_start();
    cmd_addr(8'h03, 24'h000010);
    spi_byte(8'h00, rx);
    spi_byte(8'h00, rx2);
    check("oe_during_read", 32'(bus.mem_so_oe), 1);
    cs_stop();
    check("seq_rd0", 32'(rx), 32'hA5);
    check("seq_rd1", 32'(rx2), 32'h5A);
    check("oe_after_cs", 32'(bus.mem_so_oe), 0);

    // Page mode wraps within 32 bytes
    set_mode(8'h80);
    cs_start();
    cmd_addr(8'h02, 24'h00001F);
    spi_byte(8'h11, rx);
    spi_byte(8'h22, rx);
    cs_stop();
    cs_start();
    cmd_addr(8'h03, 24'h000000);
    spi_byte(8'h00, rx);
    cs_stop();
    check("page_rd_000", 32'(rx), 32'h22);
    cs_start();
    cmd_addr(8'h03, 24'h00001F);
    spi_byte(8'h00, rx);
    spi_byte(8'h00, rx2);
    cs_stop();
    check("page_rd_01F", 32'(rx), 32'h11);
    check("page_rd_wrap", 32'(rx2), 32'h22);

    // Byte mode: only one data byte lands
    cs_start();
    cmd_addr(8'h02, 24'h000021);
    spi_byte(8'h77, rx);
    cs_stop();
    set_mode(8'h00);
    cs_start();
    cmd_addr(8'h02, 24'h000020);
    spi_byte(8'h33, rx);
    spi_byte(8'h44, rx);
    cs_stop();
    cs_start();
    spi_byte(8'h05, rx);
    spi_byte(8'h00, rx);
    cs_stop();
    check("rdmr_byte", 32'(rx), 32'h00);
    set_mode(8'h40);
    cs_start();
    cmd_addr(8'h03, 24'h000020);
    spi_byte(8'h00, rx);
    spi_byte(8'h00, rx2);
    cs_stop();
    check("byte_wr_020", 32'(rx), 32'h33);
    check("byte_wr_021", 32'(rx2), 32'h77);

    // Unsupported instruction
    p0 = err_pulses;
    o0 = oe_cnt;
    cs_start();
    spi_byte(8'h9F, rx);
    spi_byte(8'hFF, rx);
    cs_stop();
    check("bad_cmd_pulses", 32'(err_pulses - p0), 1);
    check("bad_cmd_oe", 32'(oe_cnt - o0), 0);
    check("bad_cmd_so", 32'(rx), 32'h00);
    cs_start();
    spi_byte(8'h05, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h00, rx2);
    cs_stop();
    check("rdmr_seq0", 32'(rx), 32'h40);
    check("rdmr_seq1", 32'(rx2), 32'h40);
    check("no_err_valid", 32'(err_pulses - p0), 1);

    // Aborted partial data byte
    cs_start();
    cmd_addr(8'h02, 24'h000030);
    spi_byte(8'h5C, rx);
    cs_stop();
    cs_start();
    cmd_addr(8'h02, 24'h000030);
    spi_bits(8'hFF, 5, rx);
    cs_stop();
    cs_start();
    cmd_addr(8'h03, 24'h000030);
    spi_byte(8'h00, rx);
    cs_stop();
    check("partial_no_write", 32'(rx), 32'h5C);

    // Reset in the middle of a read
    cs_start();
    cmd_addr(8'h03, 24'h000010);
    spi_bits(8'h00, 3, rx);
    check("pre_reset_bits", 32'(rx), 32'h05);
    check("pre_reset_oe", 32'(bus.mem_so_oe), 1);
    sync_reset = 1'b1;
    wait_clk(1);
    check("reset_oe", 32'(bus.mem_so_oe), 0);
    wait_clk(3);
    sync_reset = 1'b0;
    o0 = oe_cnt;
    spi_byte(8'h03, rx);
    spi_byte(8'h00, rx);
    cs_stop();
    check("post_reset_ignored_oe", 32'(oe_cnt - o0), 0);
    check("post_reset_ignored_so", 32'(rx), 32'h00);
    cs_start();
    cmd_addr(8'h03, 24'h000010);
    spi_byte(8'h00, rx);
    cs_stop();
    check("post_reset_read", 32'(rx), 32'hA5);

`ifdef SPI_SRAM_RESPONDER_HOLD_EN
    cs_start();
    cmd_addr(8'h03, 24'h000010);
    spi_bits(8'h00, 4, rhi);
    wait_clk(HALF);
    bus.mem_hold_n = 1'b0;
    wait_clk(HALF);
    check("hold_oe", 32'(bus.mem_so_oe), 0);
    for (int k = 0; k < 4; k++) begin
      bus.mem_si = 1'b1;
      wait_clk(HALF);
      bus.mem_sck = 1'b1;
      wait_clk(HALF);
      bus.mem_sck = 1'b0;
    end
    wait_clk(HALF);
    bus.mem_hold_n = 1'b1;
    spi_bits(8'h00, 4, rlo);
    spi_byte(8'h00, rx2);
    cs_stop();
    check("hold_byte", 32'({rhi[3:0], rlo[3:0]}), 32'hA5);
    check("hold_next", 32'(rx2), 32'h5A);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
